bp_fe_bp_gshare_spec: RTL and testbench

Parametrised successor to the front-end gshare predictor. Adds a configurable global-history length, and speculative history update at predict time. Also adds a history checkpoint returned with each prediction, history repair on mispredict, and a post-reset table-init sweep. It sits in the front end next to the BTB. Predictions are combinational, and resolved outcomes come back from the back end.

---
 rtl/bp_fe_gshare_pkg.sv | 29 ++
 rtl/bp_fe_bp_gshare_spec_if.sv | 26 ++
 rtl/bp_fe_sat_ctr_update.sv | 15 +
 rtl/bp_fe_bp_gshare_spec.sv | 107 ++++++++++
 tb/tb_bp_fe_bp_gshare_spec.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/bp_fe_gshare_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package bp_fe_gshare_pkg;

  localparam int unsigned hash_w_lp    = 32;
  localparam int unsigned ctr_max_w_lp = 4;

  typedef enum logic {e_init, e_ready} state_e;

  // Table index: PC bits XOR zero-extended global history.
  function automatic logic [hash_w_lp-1:0] gshare_hash(
    input logic [hash_w_lp-1:0] pc_idx,
    input logic [hash_w_lp-1:0] ghist
  );
    return pc_idx ^ ghist;
  endfunction

  // Saturating +/-1 on a counter of 'width' bits, carried in ctr_max_w_lp bits.
  function automatic logic [ctr_max_w_lp-1:0] sat_step(
    input logic [ctr_max_w_lp-1:0] ctr,
    input logic                    taken,
    input int unsigned             width
  );
    logic [ctr_max_w_lp-1:0] max_v;
    max_v = ctr_max_w_lp'((32'd1 << width) - 32'd1);
    if (taken) return (ctr >= max_v) ? ctr : ctr + ctr_max_w_lp'(1);
    else       return (ctr == '0)    ? ctr : ctr - ctr_max_w_lp'(1);
  endfunction

endpackage

// File: rtl/bp_fe_bp_gshare_spec_if.sv
// Predict/resolve bus between the front end (master) and the predictor (slave).
interface bp_fe_bp_gshare_spec_if #(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned ghist_width_p   = 8
);
  logic                       ready_o;
  logic                       r_v_i;
  logic [bht_idx_width_p-1:0] pc_idx_r_i;
  logic                       predict_o;
  logic [ghist_width_p-1:0]   ghist_o;
  logic                       w_v_i;
  logic [bht_idx_width_p-1:0] pc_idx_w_i;
  logic [ghist_width_p-1:0]   ghist_w_i;
  logic                       taken_i;
  logic                       mispredict_i;

  modport master (
    input  ready_o, predict_o, ghist_o,
    output r_v_i, pc_idx_r_i, w_v_i, pc_idx_w_i, ghist_w_i, taken_i, mispredict_i
  );

  modport slave (
    output ready_o, predict_o, ghist_o,
    input  r_v_i, pc_idx_r_i, w_v_i, pc_idx_w_i, ghist_w_i, taken_i, mispredict_i
  );
endinterface

// File: rtl/bp_fe_sat_ctr_update.sv
// Next value of a saturating direction counter given the resolved outcome.
module bp_fe_sat_ctr_update
  import bp_fe_gshare_pkg::*;
#(
  parameter int unsigned ctr_width_p = 2
) (
  input  logic [ctr_width_p-1:0] ctr_i,
  input  logic                   taken_i,
  output logic [ctr_width_p-1:0] ctr_o
);

  // Saturation lives in the package helper; widen in, narrow out.
  assign ctr_o = ctr_width_p'(sat_step(ctr_max_w_lp'(ctr_i), taken_i, ctr_width_p));

endmodule

// File: rtl/bp_fe_bp_gshare_spec.sv
// Gshare direction predictor with speculative history, checkpoint repair and init sweep.
module bp_fe_bp_gshare_spec
  import bp_fe_gshare_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned ghist_width_p   = 8,
  parameter int unsigned ctr_width_p     = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_fe_bp_gshare_spec_if.slave  bp_if
);

  localparam int unsigned els_lp = 1 << bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] init_val_lp =
    ctr_width_p'((32'd1 << (ctr_width_p - 1)) - 32'd1);
  localparam logic [bht_idx_width_p-1:0] last_idx_lp = bht_idx_width_p'(els_lp - 1);

  state_e                     state_q, state_d;
  logic [bht_idx_width_p-1:0] init_cnt_q, init_cnt_d;
  logic [ghist_width_p-1:0]   ghist_q, ghist_d;
  logic [ctr_width_p-1:0]     tbl_q [els_lp];

  logic                       ready;
  logic                       predict;
  logic                       tbl_we;
  logic [bht_idx_width_p-1:0] tbl_waddr;
  logic [ctr_width_p-1:0]     tbl_wdata;
  logic [bht_idx_width_p-1:0] ridx, widx;
  logic [ctr_width_p-1:0]     upd_ctr;

  assign ridx = bht_idx_width_p'(gshare_hash(hash_w_lp'(bp_if.pc_idx_r_i), hash_w_lp'(ghist_q)));
  assign widx = bht_idx_width_p'(gshare_hash(hash_w_lp'(bp_if.pc_idx_w_i), hash_w_lp'(bp_if.ghist_w_i)));

  bp_fe_sat_ctr_update #(.ctr_width_p(ctr_width_p)) u_sat (
    .ctr_i   (tbl_q[widx]),
    .taken_i (bp_if.taken_i),
    .ctr_o   (upd_ctr)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_init;
    else         state_q <= state_d;
  end

  // Next state: leave INIT after the last entry is written.
  always_comb begin
    state_d = state_q;
    if (state_q == e_init && init_cnt_q == last_idx_lp) state_d = e_ready;
  end

  // Outputs and shared table write port (sweep vs. resolve).
  always_comb begin
    ready     = 1'b0;
    predict   = 1'b0;
    tbl_we    = 1'b0;
    tbl_waddr = init_cnt_q;
    tbl_wdata = init_val_lp;
    if (!reset_i) begin
      if (state_q == e_init) begin
        tbl_we = 1'b1;
      end else begin
        ready     = 1'b1;
        predict   = bp_if.r_v_i & (tbl_q[ridx] > init_val_lp);
        tbl_we    = bp_if.w_v_i;
        tbl_waddr = widx;
        tbl_wdata = upd_ctr;
      end
    end
  end

  // History: repair wins over a same-cycle speculative shift.
  always_comb begin
    ghist_d    = ghist_q;
    init_cnt_d = init_cnt_q;
    if (state_q == e_init) begin
      init_cnt_d = init_cnt_q + bht_idx_width_p'(1);
      ghist_d    = '0;
    end else if (bp_if.w_v_i && bp_if.mispredict_i) begin
      ghist_d = ghist_width_p'({bp_if.ghist_w_i, bp_if.taken_i});
    end else if (bp_if.r_v_i) begin
      ghist_d = ghist_width_p'({ghist_q, predict});
    end
  end

  // Init counter and history registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      init_cnt_q <= '0;
      ghist_q    <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
      ghist_q    <= ghist_d;
    end
  end

  // Counter table; no reset, filled by the init sweep.
  always_ff @(posedge clk_i) begin
    if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  assign bp_if.ready_o   = ready;
  assign bp_if.predict_o = predict;
  assign bp_if.ghist_o   = ghist_q;

endmodule

// File: tb/tb_bp_fe_bp_gshare_spec.sv
// Directed + random bench for the gshare predictor against a table-level model.
module tb_bp_fe_bp_gshare_spec;

  localparam int unsigned IW = 4;
  localparam int unsigned GW = 4;
  localparam int unsigned CW = 2;
  localparam int ELS  = 16;
  localparam int CMAX = 3;
  localparam int INIT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bp_fe_bp_gshare_spec_if #(.bht_idx_width_p(IW), .ghist_width_p(GW)) bif ();

  bp_fe_bp_gshare_spec #(.bht_idx_width_p(IW), .ghist_width_p(GW), .ctr_width_p(CW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bp_if   (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: counters as plain ints, history as an int, init as a countdown.
  int m_ctr [ELS];
  int m_gh = 0;
  int m_init_left = ELS;

  int last_pred, last_gh, last_ready;

  task automatic expect_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational outputs vs model, advance model at the edge.
  task automatic cyc(input bit chk, input bit rst, input bit rv, input int pcr,
                     input bit wv, input int pcw, input int ghw, input bit tk, input bit mp);
    int e_ready, e_pred, e_gh, idx;
    reset            = rst;
    bif.r_v_i        = rv;
    bif.pc_idx_r_i   = 4'(pcr);
    bif.w_v_i        = wv;
    bif.pc_idx_w_i   = 4'(pcw);
    bif.ghist_w_i    = 4'(ghw);
    bif.taken_i      = tk;
    bif.mispredict_i = mp;
    #1;
    e_ready = (!rst && m_init_left == 0) ? 1 : 0;
    e_pred  = (e_ready == 1 && rv && m_ctr[(pcr ^ m_gh) % ELS] > INIT) ? 1 : 0;
    e_gh    = m_gh;
    last_ready = int'(bif.ready_o);
    last_pred  = int'(bif.predict_o);
    last_gh    = int'(bif.ghist_o);
    if (chk) begin
      expect_eq("ready_o", last_ready, e_ready);
      expect_eq("predict_o", last_pred, e_pred);
      expect_eq("ghist_o", last_gh, e_gh);
    end
    @(posedge clk);
    if (rst) begin
      m_gh = 0;
      m_init_left = ELS;
      for (int i = 0; i < ELS; i++) m_ctr[i] = INIT;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (wv) begin
        idx = (pcw ^ ghw) % ELS;
        if (tk) m_ctr[idx] = (m_ctr[idx] + 1 > CMAX) ? CMAX : m_ctr[idx] + 1;
        else    m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
      if (wv && mp)  m_gh = ((ghw << 1) | int'(tk)) % ELS;
      else if (rv)   m_gh = ((m_gh << 1) | e_pred) % ELS;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input int pcw, input int ghw, input bit tk, input bit mp);
    cyc(1, 0, 0, 0, 1, pcw, ghw, tk, mp);
  endtask

  task automatic pred(input int pcr);
    cyc(1, 0, 1, pcr, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int low_cnt;
    for (int i = 0; i < ELS; i++) m_ctr[i] = INIT;

    // Power-on reset (outputs undefined before it), then 16-cycle init sweep.
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    low_cnt = 0;
    for (int i = 0; i < ELS; i++) begin
      idle();
      if (last_ready == 0) low_cnt++;
    end
    expect_eq("init_ready_low_cycles", low_cnt, ELS);
    idle();
    expect_eq("init_ready_high", last_ready, 1);

    // Every entry weakly not-taken after init.
    for (int p = 0; p < ELS; p++) pred(p);

    // Up-saturation at idx 5, ghist 0.
    for (int i = 0; i < 4; i++) upd(5, 0, 1, 0);
    pred(5);
    expect_eq("upsat_predict", last_pred, 1);
    // Restore ghist to 0 through a repair on idx 0.
    upd(0, 0, 0, 1);
    idle();
    expect_eq("repair_to_zero", last_gh, 0);
    // Down-saturation: 3 -> 0 and beyond, then one step up must give 1 (not taken).
    for (int i = 0; i < 5; i++) upd(5, 0, 0, 0);
    upd(5, 0, 1, 0);
    pred(5);
    expect_eq("downsat_no_wrap", last_pred, 0);

    // Speculative history on a fresh table.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < ELS; i++) idle();
    upd(3, 0, 1, 0); upd(3, 0, 1, 0);
    upd(6, 0, 1, 0); upd(6, 0, 1, 0);
    pred(3);
    expect_eq("spec_p1_pred", last_pred, 1);
    expect_eq("spec_p1_gh", last_gh, 0);
    pred(7);
    expect_eq("spec_p2_pred", last_pred, 1);
    expect_eq("spec_p2_gh", last_gh, 1);
    idle();
    expect_eq("spec_gh_after", last_gh, 3);

    // Repair beats a same-cycle predict.
    upd(0, 5, 0, 1);
    idle();
    expect_eq("repair_setup_gh", last_gh, 10);
    cyc(1, 0, 1, 2, 1, 1, 3, 1, 1);
    idle();
    expect_eq("repair_gh", last_gh, 7);

    // Reset in the middle of INIT restarts the full sweep.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) idle();
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    low_cnt = 0;
    for (int i = 0; i < ELS; i++) begin
      cyc(1, 0, 1, $urandom_range(0, 15), 1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 1);
      if (last_ready == 0) low_cnt++;
    end
    expect_eq("midinit_ready_low_cycles", low_cnt, ELS);
    idle();
    expect_eq("midinit_ready_high", last_ready, 1);
    expect_eq("midinit_gh", last_gh, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
          1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
